// File: rtl/quadrilatero_instr_pkg.sv
// Quadrilatero instruction patterns on custom-1 (opcode 0x2B); match after masking
// opcode, funct3 and funct7, leaving register fields free.
package quadrilatero_instr_pkg;

  localparam logic [31:0] QMASK    = 32'hFE00707F;

  localparam logic [31:0] MMASA_W  = 32'h0000002B;
  localparam logic [31:0] MMADA_H  = 32'h0200002B;
  localparam logic [31:0] MMAQA_B  = 32'h0400002B;
  localparam logic [31:0] FMMACC_S = 32'h1000002B;
  localparam logic [31:0] FMMACC_D = 32'h1200002B;
  localparam logic [31:0] FMMACC_H = 32'h1400002B;
  localparam logic [31:0] MZERO    = 32'h4000002B;
  localparam logic [31:0] MLD_B    = 32'h0000102B;
  localparam logic [31:0] MLD_H    = 32'h0200102B;
  localparam logic [31:0] MLD_W    = 32'h0400102B;
  localparam logic [31:0] MST_B    = 32'h0000202B;
  localparam logic [31:0] MST_H    = 32'h0200202B;
  localparam logic [31:0] MST_W    = 32'h0400202B;

endpackage

// File: rtl/xif_pkg.sv
// XIF issue-interface types shared between the core and the matrix unit.
package xif_pkg;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic [2:0] dualwrite;
    logic [2:0] dualread;
    logic       loadstore;
    logic       ecswrite;
    logic       exc;
  } x_issue_resp_t;

endpackage

// File: rtl/quadrilatero_issue_buffer.sv
// XIF issue front-end: decodes offloaded instructions and holds accepted ones in an
// in-order buffer until committed (dispatched in order) or killed (dropped).
module quadrilatero_issue_buffer
  import xif_pkg::*;
  import quadrilatero_instr_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter bit          FP_EN    = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [ID_WIDTH-1:0]          issue_id_i,
  output x_issue_resp_t                issue_resp_o,
  input  logic                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         disp_valid_o,
  input  logic                         disp_ready_i,
  output logic [31:0]                  disp_instr_o,
  output logic [ID_WIDTH-1:0]          disp_id_o,
  output logic [1:0]                   disp_class_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [31:0]         instr_q     [DEPTH];
  logic [ID_WIDTH-1:0] id_q        [DEPTH];
  logic [1:0]          class_q     [DEPTH];
  logic [DEPTH-1:0]    committed_q;
  logic [DEPTH-1:0]    killed_q;
  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q;

  logic [31:0]      dec_word;
  logic             dec_ok;
  logic [1:0]       dec_cls;
  x_issue_resp_t    resp;
  logic             push, pop;
  logic [DEPTH-1:0] commit_hit;
  logic             commit_found;
  logic             commit_new;
  logic [PtrW-1:0]  scan_idx;

  always_comb begin
    dec_ok   = 1'b0;
    dec_cls  = 2'd0;
    dec_word = issue_instr_i & QMASK;
    case (dec_word)
      MMASA_W, MMADA_H, MMAQA_B: begin dec_ok = 1'b1;  dec_cls = 2'd0; end
      FMMACC_S, FMMACC_D, FMMACC_H: begin dec_ok = FP_EN; dec_cls = 2'd0; end
      MLD_B, MLD_H, MLD_W:       begin dec_ok = 1'b1;  dec_cls = 2'd1; end
      MST_B, MST_H, MST_W:       begin dec_ok = 1'b1;  dec_cls = 2'd2; end
      MZERO:                     begin dec_ok = 1'b1;  dec_cls = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    resp           = '0;
    resp.accept    = dec_ok;
    resp.loadstore = dec_ok & ((dec_cls == 2'd1) | (dec_cls == 2'd2));
  end

  assign issue_resp_o  = resp;
  assign issue_ready_o = !rst_i && (count_q < CntW'(DEPTH));
  assign push          = issue_valid_i & issue_ready_o & dec_ok;

  // Oldest live entry with this id that has not yet been committed or killed.
  always_comb begin
    commit_hit   = '0;
    commit_found = 1'b0;
    scan_idx     = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      scan_idx = head_q + PtrW'(k);
      if (!commit_found && (k < int'(count_q)) && (id_q[scan_idx] == commit_id_i) &&
          !committed_q[scan_idx] && !killed_q[scan_idx]) begin
        commit_hit[scan_idx] = commit_valid_i;
        commit_found         = 1'b1;
      end
    end
    commit_new = commit_valid_i & push & !commit_found & (issue_id_i == commit_id_i);
  end

  assign disp_valid_o = (count_q != '0) && committed_q[head_q] && !killed_q[head_q];
  assign pop          = (count_q != '0) && (killed_q[head_q] || (disp_valid_o && disp_ready_i));
  assign disp_instr_o = instr_q[head_q];
  assign disp_id_o    = id_q[head_q];
  assign disp_class_o = class_q[head_q];
  assign occupancy_o  = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        class_q[i] <= '0;
      end
      committed_q <= '0;
      killed_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          if (commit_kill_i) killed_q[i]    <= 1'b1;
          else               committed_q[i] <= 1'b1;
        end
      end
      if (push) begin
        instr_q[tail_q]     <= issue_instr_i;
        id_q[tail_q]        <= issue_id_i;
        class_q[tail_q]     <= dec_cls;
        committed_q[tail_q] <= commit_new & !commit_kill_i;
        killed_q[tail_q]    <= commit_new & commit_kill_i;
        tail_q              <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrilatero_issue_buffer.sv
// Directed bench for quadrilatero_issue_buffer: decode, commit/kill ordering, full buffer
// back-pressure and asynchronous reset, against hand-computed values.
module tb_quadrilatero_issue_buffer;

  localparam logic [31:0] W_MLD_W   = 32'h040010AB;
  localparam logic [31:0] W_MST_B   = 32'h0000202B;
  localparam logic [31:0] W_FMMAC_S = 32'h1000002B;
  localparam logic [31:0] W_MZERO   = 32'h4000002B;
  localparam logic [31:0] W_ILLEGAL = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_instr = '0;
  logic [3:0]  issue_id = '0;
  xif_pkg::x_issue_resp_t issue_resp;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        disp_valid;
  logic        disp_ready = 1'b0;
  logic [31:0] disp_instr;
  logic [3:0]  disp_id;
  logic [1:0]  disp_class;
  logic [2:0]  occupancy;

  logic        issue_valid2 = 1'b0;
  logic [31:0] issue_instr2 = '0;
  logic        issue_ready2;
  xif_pkg::x_issue_resp_t issue_resp2;
  logic        disp_valid2;
  logic [31:0] disp_instr2;
  logic [3:0]  disp_id2;
  logic [1:0]  disp_class2;
  logic [2:0]  occupancy2;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        seen_id2 = 1'b0;
  logic        track_id2 = 1'b0;

  always #5 clk = ~clk;

  quadrilatero_issue_buffer #(.DEPTH(4), .ID_WIDTH(4), .FP_EN(1'b1)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_instr_i  (issue_instr),
    .issue_id_i     (issue_id),
    .issue_resp_o   (issue_resp),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .disp_valid_o   (disp_valid),
    .disp_ready_i   (disp_ready),
    .disp_instr_o   (disp_instr),
    .disp_id_o      (disp_id),
    .disp_class_o   (disp_class),
    .occupancy_o    (occupancy)
  );

  quadrilatero_issue_buffer #(.DEPTH(4), .ID_WIDTH(4), .FP_EN(1'b0)) u_dut_nofp (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid2),
    .issue_ready_o  (issue_ready2),
    .issue_instr_i  (issue_instr2),
    .issue_id_i     (4'd0),
    .issue_resp_o   (issue_resp2),
    .commit_valid_i (1'b0),
    .commit_id_i    (4'd0),
    .commit_kill_i  (1'b0),
    .disp_valid_o   (disp_valid2),
    .disp_ready_i   (1'b0),
    .disp_instr_o   (disp_instr2),
    .disp_id_o      (disp_id2),
    .disp_class_o   (disp_class2),
    .occupancy_o    (occupancy2)
  );

  always @(negedge clk) begin
    if (track_id2 && disp_valid && disp_id == 4'd2) seen_id2 <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [31:0] w, input logic [3:0] id);
    issue_valid = v;
    issue_instr = w;
    issue_id    = id;
  endtask

  task automatic set_commit(input logic v, input logic [3:0] id, input logic kill);
    commit_valid = v;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_dvalid", 32'(disp_valid), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_dinstr", disp_instr, 32'd0);

    // MLD_W id 3, then commit and dispatch
    set_issue(1'b1, W_MLD_W, 4'd3);
    #1;
    check("mld_accept", 32'(issue_resp.accept), 32'd1);
    check("mld_ls", 32'(issue_resp.loadstore), 32'd1);
    tick();
    set_issue(1'b0, '0, '0);
    check("mld_occ1", 32'(occupancy), 32'd1);
    check("mld_nodisp", 32'(disp_valid), 32'd0);
    set_commit(1'b1, 4'd3, 1'b0);
    tick();
    set_commit(1'b0, '0, 1'b0);
    check("mld_dvalid", 32'(disp_valid), 32'd1);
    check("mld_did", 32'(disp_id), 32'd3);
    check("mld_dclass", 32'(disp_class), 32'd1);
    check("mld_dinstr", disp_instr, W_MLD_W);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check("mld_occ0", 32'(occupancy), 32'd0);
    check("mld_dvalid0", 32'(disp_valid), 32'd0);

    // Illegal word
    set_issue(1'b1, W_ILLEGAL, 4'd1);
    #1;
    check("ill_resp", 32'(issue_resp), 32'd0);
    tick();
    set_issue(1'b0, '0, '0);
    check("ill_occ", 32'(occupancy), 32'd0);
    check("ill_dvalid", 32'(disp_valid), 32'd0);

    // FMMACC_S: rejected without FP, accepted with FP; commit lands in same cycle as push
    set_issue(1'b1, W_FMMAC_S, 4'd5);
    issue_valid2 = 1'b1;
    issue_instr2 = W_FMMAC_S;
    set_commit(1'b1, 4'd5, 1'b0);
    #1;
    check("fp0_accept", 32'(issue_resp2.accept), 32'd0);
    check("fp0_resp", 32'(issue_resp2), 32'd0);
    check("fp1_accept", 32'(issue_resp.accept), 32'd1);
    check("fp1_ls", 32'(issue_resp.loadstore), 32'd0);
    tick();
    set_issue(1'b0, '0, '0);
    set_commit(1'b0, '0, 1'b0);
    issue_valid2 = 1'b0;
    check("fp0_occ", 32'(occupancy2), 32'd0);
    check("fp1_dvalid", 32'(disp_valid), 32'd1);
    check("fp1_did", 32'(disp_id), 32'd5);
    check("fp1_dclass", 32'(disp_class), 32'd0);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check("fp1_occ0", 32'(occupancy), 32'd0);

    // Fill DEPTH=4 with ids 0..3, 5th held until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      set_issue(1'b1, W_MZERO, 4'(i));
      tick();
    end
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_ready", 32'(issue_ready), 32'd0);
    set_issue(1'b1, W_MZERO, 4'd4);
    tick();
    check("full_held_occ", 32'(occupancy), 32'd4);
    set_commit(1'b1, 4'd0, 1'b0);
    disp_ready = 1'b1;
    tick();
    set_commit(1'b0, '0, 1'b0);
    check("full_dvalid", 32'(disp_valid), 32'd1);
    check("full_did", 32'(disp_id), 32'd0);
    check("full_dclass", 32'(disp_class), 32'd3);
    check("full_ready_pop", 32'(issue_ready), 32'd0);
    tick();
    disp_ready = 1'b0;
    check("full_ready_back", 32'(issue_ready), 32'd1);
    check("full_occ3", 32'(occupancy), 32'd3);
    check("full_stall", 32'(disp_valid), 32'd0);
    tick();
    set_issue(1'b0, '0, '0);
    check("full_5th_in", 32'(occupancy), 32'd4);
    for (int i = 1; i < 5; i++) begin
      set_commit(1'b1, 4'(i), 1'b1);
      tick();
      check("drain_nodisp", 32'(disp_valid), 32'd0);
    end
    set_commit(1'b0, '0, 1'b0);
    tick();
    check("drain_occ", 32'(occupancy), 32'd0);

    // Kill 2, commit 1 and 3: dispatch 1, one idle cycle, then 3
    for (int i = 1; i < 4; i++) begin
      set_issue(1'b1, W_MST_B, 4'(i));
      tick();
    end
    set_issue(1'b0, '0, '0);
    track_id2  = 1'b1;
    disp_ready = 1'b1;
    set_commit(1'b1, 4'd2, 1'b1);
    tick();
    check("kill_stall", 32'(disp_valid), 32'd0);
    set_commit(1'b1, 4'd1, 1'b0);
    tick();
    check("kill_d1_valid", 32'(disp_valid), 32'd1);
    check("kill_d1_id", 32'(disp_id), 32'd1);
    check("kill_d1_class", 32'(disp_class), 32'd2);
    set_commit(1'b1, 4'd3, 1'b0);
    tick();
    set_commit(1'b0, '0, 1'b0);
    check("kill_idle", 32'(disp_valid), 32'd0);
    check("kill_idle_occ", 32'(occupancy), 32'd2);
    tick();
    check("kill_d3_valid", 32'(disp_valid), 32'd1);
    check("kill_d3_id", 32'(disp_id), 32'd3);
    tick();
    disp_ready = 1'b0;
    track_id2  = 1'b0;
    check("kill_occ0", 32'(occupancy), 32'd0);
    check("kill_no_id2", 32'(seen_id2), 32'd0);

    // Asynchronous reset with three live entries
    for (int i = 7; i < 10; i++) begin
      set_issue(1'b1, W_MZERO, 4'(i));
      tick();
    end
    set_issue(1'b0, '0, '0);
    set_commit(1'b1, 4'd7, 1'b0);
    tick();
    set_commit(1'b0, '0, 1'b0);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    check("pre_rst_dvalid", 32'(disp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_dvalid", 32'(disp_valid), 32'd0);
    check("arst_ready", 32'(issue_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(issue_ready), 32'd1);
    set_commit(1'b1, 4'd8, 1'b0);
    tick();
    set_commit(1'b0, '0, 1'b0);
    check("stale_commit_occ", 32'(occupancy), 32'd0);
    set_issue(1'b1, W_MZERO, 4'd8);
    tick();
    set_issue(1'b0, '0, '0);
    tick();
    check("stale_commit_new", 32'(occupancy), 32'd1);
    check("stale_commit_nodisp", 32'(disp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/quadrilatero_issue_buffer.md
# quadrilatero_issue_buffer

Parametrised XIF issue front-end for the quadrilatero matrix unit: decodes each offloaded instruction, returns the issue response, and holds accepted instructions in a DEPTH-entry in-order buffer until the core commits or kills them. Committed instructions are dispatched in program order to the matrix dispatcher; killed ones are dropped. It sits between the core's XIF issue/commit ports and the quadrilatero dispatcher, replacing the purely combinational issue decode.

## Interface
- DEPTH, 4: buffer entries, power of two, ≥2
- ID_WIDTH, 4: XIF instruction id width
- FP_EN, 1: 1 accepts FMMACC_S/D/H; 0 rejects them (accept=0)
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  buffer can take an issue
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_resp_o  out  xif_pkg::x_issue_resp_t  response, valid with issue_valid_i
- commit_valid_i  in  1  commit/kill event
- commit_id_i  in  ID_WIDTH  id being committed
- commit_kill_i  in  1  1 = kill, 0 = commit
- disp_valid_o  out  1  head instruction ready for dispatch
- disp_ready_i  in  1  dispatcher takes head
- disp_instr_o  out  32  head instruction word
- disp_id_o  out  ID_WIDTH  head id
- disp_class_o  out  2  0 matmul, 1 load, 2 store, 3 zero
- occupancy_o  out  $clog2(DEPTH+1)  live entries

## Operation
- Decode (combinational, from quadrilatero_instr_pkg patterns): MMAQA_B/MMADA_H/MMASA_W/FMMACC_* → class 0; MLD_B/H/W → class 1; MST_B/H/W → class 2; MZERO → class 3. All recognised: accept=1, loadstore=1 for classes 1/2, every other response field 0. Unrecognised, or FMMACC_* with FP_EN=0: issue_resp_o = '0.
- Issue handshake completes on issue_valid_i & issue_ready_o. Accepted → push {instr, id, class, committed=0, killed=0} at tail. Rejected → handshake completes, nothing pushed.
- issue_ready_o = occupancy_o < DEPTH, 0 while rst_i high. No push/pop bypass: full buffer stays not-ready in the pop cycle.
- Commit: commit_valid_i marks the oldest live, not-yet-committed entry with matching id: committed=1 (kill=0) or killed=1 (kill=1). No match → ignored. Commit arriving in the same cycle as the push of that id applies to the new entry.
- Head: killed → popped silently, one per cycle, disp_valid_o=0. Committed & not killed → disp_valid_o=1; pop on disp_valid_o & disp_ready_i. Uncommitted → stall.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter +1 push, −1 pop, unchanged on simultaneous push+pop.

## Timing
- Reset (async assert, sync release): pointers, counter, flags 0; disp_valid_o=0, occupancy_o=0, disp_* data 0; issue_ready_o=1 first cycle after release.
- Issue response: 0-cycle combinational.
- Issue → earliest dispatch: 1 cycle after commit edge; commit in same cycle as push → disp_valid_o in next cycle.
- disp_* outputs registered from buffer storage; stable while disp_valid_o & !disp_ready_i.
- Killed head consumes one cycle; throughput 1 dispatch/cycle otherwise.
- Reset mid-operation discards all entries; no outputs glitch high.

## Test plan
- MLD_W, id 3, issued then committed → issue_resp_o.accept=1, loadstore=1; disp_valid_o next cycle, disp_id_o=3, disp_class_o=1, occupancy 1→0 on disp_ready_i.
- Illegal word 0x00000013 issued → issue_resp_o='0, occupancy_o stays 0, no dispatch.
- FP_EN=0, FMMACC_S → accept=0; FP_EN=1 → accept=1, class 0.
- DEPTH=4: issue ids 0..4 without commit → issue_ready_o=0 after 4th; 5th held; commit id 0 + disp_ready_i=1 → ready returns cycle after pop, 5th accepted.
- Issue ids 1,2,3; kill 2, commit 1 and 3 → dispatch order 1, 3; id 2 never on disp_id_o; one idle cycle between.
- Assert rst_i with 3 entries, disp_ready_i=0 → occupancy_o=0, disp_valid_o=0 immediately; commit for old id after release ignored.
